// File: rtl/jtframe_sim_input_pkg.sv
// Shared constants for the simulation input sequencer: joystick bit map,
// phase patterns and default frame schedule. Revision 1.0
`default_nettype none

package jtframe_sim_input_pkg;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_B1    = 4;
  localparam int JOY_B2    = 5;
  localparam int JOY_B3    = 6;
  localparam int JOY_W     = 7;

  // Active-high patterns, one per movement phase
  localparam logic [JOY_W-1:0] PHASE_PAT [8] = '{
    7'h01, 7'h02, 7'h04, 7'h08, 7'h11, 7'h12, 7'h20, 7'h00
  };

  localparam int DEF_COIN_FRAME   = 60;
  localparam int DEF_START_FRAME  = 120;
  localparam int DEF_PULSE_FRAMES = 4;
  localparam int DEF_MOVE_START   = 180;
  localparam int DEF_MOVE_PERIOD  = 32;

endpackage

`default_nettype wire

// File: rtl/jtframe_sim_input_pattern.sv
// Phase to active-high joystick pattern. Autofire on b1 during phases 0-3
// when JTFRAME_SIM_AUTOFIRE_EN is defined. Revision 1.0
`default_nettype none

module jtframe_sim_input_pattern
  import jtframe_sim_input_pkg::*;
(
  input  logic [2:0]       phase,
  input  logic             autofire,
  output logic [JOY_W-1:0] pattern
);

`ifdef JTFRAME_SIM_AUTOFIRE_EN
  always_comb begin
    pattern = PHASE_PAT[phase];
    if (!phase[2]) pattern[JOY_B1] = autofire;
  end
`else
  logic unused_autofire;
  assign unused_autofire = autofire;

  always_comb begin
    pattern = PHASE_PAT[phase];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/jtframe_sim_input_seq.sv
// Scripted coin/start/joystick-1 generator paced by LVBL falling edges.
// Optional autofire: JTFRAME_SIM_AUTOFIRE_EN. Revision 1.0
`default_nettype none

module jtframe_sim_input_seq
  import jtframe_sim_input_pkg::*;
#(
  parameter int COIN_FRAME   = DEF_COIN_FRAME,
  parameter int START_FRAME  = DEF_START_FRAME,
  parameter int PULSE_FRAMES = DEF_PULSE_FRAMES,
  parameter int MOVE_START   = DEF_MOVE_START,
  parameter int MOVE_PERIOD  = DEF_MOVE_PERIOD
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_rst,
  input  logic             LVBL,
  output logic [JOY_W-1:0] game_joystick1,
  output logic             button_1p,
  output logic             coin_left,
  output logic [15:0]      frame_cnt
);

  localparam int PW = $clog2(MOVE_PERIOD);

  logic          lvbl_l;
  logic          frame_ev;
  logic [15:0]   frame_q, frame_d;
  logic [PW-1:0] per_q, per_d;
  logic [2:0]    phase_q, phase_d;
  logic          moving_q, moving_d;
  logic [JOY_W-1:0] pattern;
  logic [JOY_W-1:0] joy_d;
  logic          coin_d, start_d;

  assign frame_ev  = lvbl_l & ~LVBL;
  assign frame_cnt = frame_q;

  always_comb begin
    frame_d  = frame_q;
    per_d    = per_q;
    phase_d  = phase_q;
    moving_d = moving_q;
    if (loop_rst) begin
      frame_d  = '0;
      per_d    = '0;
      phase_d  = '0;
      moving_d = 1'b0;
    end else if (frame_ev) begin
      if (frame_q != 16'hFFFF) frame_d = frame_q + 16'd1;
      if (!moving_q) begin
        // >= rather than == so MOVE_START=0 still engages on the first frame
        if (int'(frame_d) >= MOVE_START) moving_d = 1'b1;
      end else if (per_q == PW'(MOVE_PERIOD - 1)) begin
        per_d   = '0;
        phase_d = phase_q + 3'd1;
      end else begin
        per_d = per_q + PW'(1);
      end
    end
  end

  jtframe_sim_input_pattern u_pattern (
    .phase    (phase_q),
    .autofire (frame_q[1]),
    .pattern  (pattern)
  );

  always_comb begin
    joy_d   = moving_q ? ~pattern : {JOY_W{1'b1}};
    coin_d  = !(int'(frame_q) >= COIN_FRAME  && int'(frame_q) < COIN_FRAME  + PULSE_FRAMES);
    start_d = !(int'(frame_q) >= START_FRAME && int'(frame_q) < START_FRAME + PULSE_FRAMES);
    if (loop_rst) begin
      joy_d   = {JOY_W{1'b1}};
      coin_d  = 1'b1;
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_l         <= 1'b1;
      frame_q        <= '0;
      per_q          <= '0;
      phase_q        <= '0;
      moving_q       <= 1'b0;
      game_joystick1 <= {JOY_W{1'b1}};
      button_1p      <= 1'b1;
      coin_left      <= 1'b1;
    end else begin
      lvbl_l         <= LVBL;
      frame_q        <= frame_d;
      per_q          <= per_d;
      phase_q        <= phase_d;
      moving_q       <= moving_d;
      game_joystick1 <= joy_d;
      button_1p      <= start_d;
      coin_left      <= coin_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_sim_input_seq.sv
// Directed bench for jtframe_sim_input_seq with a scoreboard of expected outputs.
// Revision 1.0
`default_nettype none

module tb_jtframe_sim_input_seq;

  localparam int COIN   = 60;
  localparam int START  = 120;
  localparam int PULSE  = 4;
  localparam int MSTART = 180;
  localparam int MPER   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        loop_rst = 1'b0;
  logic        LVBL = 1'b1;
  logic [6:0]  game_joystick1;
  logic        button_1p;
  logic        coin_left;
  logic [15:0] frame_cnt;

  jtframe_sim_input_seq #(
    .COIN_FRAME   (COIN),
    .START_FRAME  (START),
    .PULSE_FRAMES (PULSE),
    .MOVE_START   (MSTART),
    .MOVE_PERIOD  (MPER)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .loop_rst       (loop_rst),
    .LVBL           (LVBL),
    .game_joystick1 (game_joystick1),
    .button_1p      (button_1p),
    .coin_left      (coin_left),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] joy;
    logic       btn;
    logic       coin;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  int m_cnt   = 0;
  int m_per   = 0;
  int m_phase = 0;
  bit m_mov   = 1'b0;

  function automatic exp_t model_out();
    exp_t       e;
    logic [6:0] p;
    logic [15:0] c;
    c = m_cnt[15:0];
    p = 7'h00;
    if (m_mov) begin
      case (m_phase)
        0: p = 7'b0000001;
        1: p = 7'b0000010;
        2: p = 7'b0000100;
        3: p = 7'b0001000;
        4: p = 7'b0010001;
        5: p = 7'b0010010;
        6: p = 7'b0100000;
        default: p = 7'b0000000;
      endcase
`ifdef JTFRAME_SIM_AUTOFIRE_EN
      if (m_phase < 4) p[4] = c[1];
`endif
    end
    e.joy  = ~p;
    e.btn  = !(m_cnt >= START && m_cnt < START + PULSE);
    e.coin = !(m_cnt >= COIN  && m_cnt < COIN  + PULSE);
    return e;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_per = 0; m_phase = 0; m_mov = 1'b0;
  endtask

  task automatic model_event();
    if (m_cnt < 65535) m_cnt++;
    if (!m_mov) begin
      if (m_cnt >= MSTART) m_mov = 1'b1;
    end else if (m_per == MPER - 1) begin
      m_per = 0;
      m_phase = (m_phase + 1) % 8;
    end else begin
      m_per++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, "_joy"},  32'(game_joystick1), 32'(e.joy));
    chk({tag, "_btn"},  32'(button_1p),      32'(e.btn));
    chk({tag, "_coin"}, 32'(coin_left),      32'(e.coin));
  endtask

  // One LVBL falling edge: counter moves one clock after, outputs one clock later
  task automatic frame_edge();
    @(negedge clk) LVBL = 1'b0;
    @(posedge clk);
    model_event();
    q.push_back(model_out());
    #1;
    chk("cnt_e1", 32'(frame_cnt), 32'(m_cnt));
    check_outs("lat_hold", last);
    @(posedge clk);
    #1;
    last = q.pop_front();
    check_outs("out", last);
    @(negedge clk) LVBL = 1'b1;
  endtask

  task automatic do_loop_rst(input bit with_edge);
    @(negedge clk);
    loop_rst = 1'b1;
    if (with_edge) LVBL = 1'b0;
    @(posedge clk);
    model_clear();
    #1 chk("lrst_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) loop_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lrst_cnt_after", 32'(frame_cnt), 32'd0);
    chk("lrst_joy", 32'(game_joystick1), 32'h7F);
    chk("lrst_btn", 32'(button_1p), 32'd1);
    chk("lrst_coin", 32'(coin_left), 32'd1);
    @(negedge clk) LVBL = 1'b1;
    last = model_out();
  endtask

  int tbl_edge [7] = '{180, 212, 244, 308, 372, 404, 436};
  logic [6:0] tbl_joy [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h6E, 7'h5F, 7'h7F, 7'h7E};

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_joy",  32'(game_joystick1), 32'h7F);
    chk("rst_btn",  32'(button_1p),      32'd1);
    chk("rst_coin", 32'(coin_left),      32'd1);
    chk("rst_cnt",  32'(frame_cnt),      32'd0);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    last = model_out();

    // Coin, start and movement schedule
    for (int e = 1; e <= 468; e++) begin
      frame_edge();
      if (e == 59)  chk("cnt59", 32'(frame_cnt), 32'd59);
      if (e == 60)  chk("coin_on60", 32'(coin_left), 32'd0);
      if (e == 64)  chk("coin_off64", 32'(coin_left), 32'd1);
      if (e >= 120 && e <= 123) chk("btn_on", 32'(button_1p), 32'd0);
      if (e == 124) chk("btn_off124", 32'(button_1p), 32'd1);
      for (int k = 0; k < 7; k++)
        if (e == tbl_edge[k]) chk("joy_tbl", 32'(game_joystick1), 32'(tbl_joy[k]));
    end

    // Restart, then restart again at frame 200 coincident with an edge
    do_loop_rst(1'b0);
    for (int e = 1; e <= 200; e++) frame_edge();
    do_loop_rst(1'b1);
    for (int e = 1; e <= 64; e++) begin
      frame_edge();
      if (e == 60) chk("coin_again", 32'(coin_left), 32'd0);
    end

    // LVBL held low for 1000 clocks counts once
    @(negedge clk) LVBL = 1'b0;
    @(posedge clk);
    model_event();
    q.push_back(model_out());
    repeat (1000) @(posedge clk);
    #1;
    last = q.pop_front();
    check_outs("held", last);
    chk("held_cnt", 32'(frame_cnt), 32'd65);
    @(negedge clk) LVBL = 1'b1;

    // Asynchronous reset mid-movement
    while (m_cnt < 185) frame_edge();
    chk("pre_arst_joy", 32'(game_joystick1), 32'h7E);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_joy",  32'(game_joystick1), 32'h7F);
    chk("arst_btn",  32'(button_1p),      32'd1);
    chk("arst_coin", 32'(coin_left),      32'd1);
    chk("arst_cnt",  32'(frame_cnt),      32'd0);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    last = model_out();

    // Saturation with movement still advancing
    while (m_cnt < 181) frame_edge();
    @(negedge clk) force dut.frame_q = 16'hFFF0;
    @(posedge clk);
    @(negedge clk) release dut.frame_q;
    m_cnt = 16'hFFF0;
    #1 chk("force_cnt", 32'(frame_cnt), 32'hFFF0);
    for (int e = 0; e < 48; e++) frame_edge();
    chk("sat_cnt", 32'(frame_cnt), 32'hFFFF);
    chk("sat_phase_joy", 32'(game_joystick1), 32'h7D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
